// File: rtl/ps2_pkt_assembler_if.sv
// Byte-side and packet-side signals of the PS/2 packet assembler.
// master = upstream byte receiver / packet consumer, slave = assembler.
interface ps2_pkt_assembler_if;
  logic        byte_vld;
  logic [7:0]  byte_data;
  logic        byte_err;
  logic        ps2pkt_vld;
  logic [23:0] ps2pkt_data;
  logic        sync_err;
  logic        timeout_err;
  logic [15:0] pkt_cnt;

  modport master (
    output byte_vld, byte_data, byte_err,
    input  ps2pkt_vld, ps2pkt_data, sync_err, timeout_err, pkt_cnt
  );

  modport slave (
    input  byte_vld, byte_data, byte_err,
    output ps2pkt_vld, ps2pkt_data, sync_err, timeout_err, pkt_cnt
  );
endinterface

// File: rtl/ps2_pkt_assembler.sv
// Collects the three bytes of a PS/2 stream-mode mouse packet into one word,
// dropping misaligned, errored or stalled partial packets.
module ps2_pkt_assembler #(
  parameter int TIMEOUT_CYC = 100000,
  parameter int CNT_W       = 20
) (
  input  logic               clk_sys,
  input  logic               rst_n,
  input  logic               en,
  ps2_pkt_assembler_if.slave bus
);
  typedef enum logic [1:0] {
    WAIT_B0,
    WAIT_B1,
    WAIT_B2
  } state_t;

  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TIMEOUT_CYC - 1);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [7:0]        byte0_reg, byte0_next;
  logic [7:0]        byte1_reg, byte1_next;
  logic [23:0]       pkt_data_reg, pkt_data_next;
  logic              pkt_vld_reg, pkt_vld_next;
  logic              sync_err_reg, sync_err_next;
  logic              timeout_err_reg, timeout_err_next;
  logic [15:0]       pkt_cnt_reg, pkt_cnt_next;
  logic              timeout_hit;

  assign timeout_hit = (cnt_reg == TERM_CNT);

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= WAIT_B0;
      cnt_reg         <= '0;
      byte0_reg       <= '0;
      byte1_reg       <= '0;
      pkt_data_reg    <= '0;
      pkt_vld_reg     <= 1'b0;
      sync_err_reg    <= 1'b0;
      timeout_err_reg <= 1'b0;
      pkt_cnt_reg     <= '0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      byte0_reg       <= byte0_next;
      byte1_reg       <= byte1_next;
      pkt_data_reg    <= pkt_data_next;
      pkt_vld_reg     <= pkt_vld_next;
      sync_err_reg    <= sync_err_next;
      timeout_err_reg <= timeout_err_next;
      pkt_cnt_reg     <= pkt_cnt_next;
    end
  end

  // Priority: disable, then byte_err, then an accepted byte, then timeout.
  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    byte0_next       = byte0_reg;
    byte1_next       = byte1_reg;
    pkt_data_next    = pkt_data_reg;
    pkt_vld_next     = 1'b0;
    sync_err_next    = 1'b0;
    timeout_err_next = 1'b0;
    pkt_cnt_next     = pkt_cnt_reg;

    if (!en) begin
      state_next = WAIT_B0;
      cnt_next   = '0;
    end else if (bus.byte_err) begin
      state_next = WAIT_B0;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        WAIT_B0: begin
          cnt_next = '0;
          if (bus.byte_vld) begin
            if (bus.byte_data[3]) begin
              byte0_next = bus.byte_data;
              state_next = WAIT_B1;
            end else begin
              sync_err_next = 1'b1;
            end
          end
        end
        WAIT_B1: begin
          if (bus.byte_vld) begin
            byte1_next = bus.byte_data;
            cnt_next   = '0;
            state_next = WAIT_B2;
          end else if (timeout_hit) begin
            cnt_next         = '0;
            state_next       = WAIT_B0;
            timeout_err_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        WAIT_B2: begin
          if (bus.byte_vld) begin
            pkt_data_next = {bus.byte_data, byte1_reg, byte0_reg};
            pkt_vld_next  = 1'b1;
            pkt_cnt_next  = pkt_cnt_reg + 16'd1;
            cnt_next      = '0;
            state_next    = WAIT_B0;
          end else if (timeout_hit) begin
            cnt_next         = '0;
            state_next       = WAIT_B0;
            timeout_err_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          state_next = WAIT_B0;
          cnt_next   = '0;
        end
      endcase
    end
  end

  assign bus.ps2pkt_vld  = pkt_vld_reg;
  assign bus.ps2pkt_data = pkt_data_reg;
  assign bus.sync_err    = sync_err_reg;
  assign bus.timeout_err = timeout_err_reg;
  assign bus.pkt_cnt     = pkt_cnt_reg;
endmodule

// File: tb/tb_ps2_pkt_assembler.sv
// Directed bench for ps2_pkt_assembler: packet table plus hand-written
// sequences for sync, timeout, byte_err, reset, enable and counter wrap.
module tb_ps2_pkt_assembler;
  localparam int TO = 1200;
  localparam int CW = 11;

  logic clk_sys = 1'b0;
  logic rst_n   = 1'b0;
  logic en      = 1'b0;

  ps2_pkt_assembler_if bus();

  ps2_pkt_assembler #(.TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .en      (en),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    int          gap;
    logic [23:0] exp_data;
  } pkt_vec_t;

  int n_cmp  = 0;
  int n_fail = 0;
  int seen_vld = 0, seen_sync = 0, seen_to = 0, seen_multi = 0, seen_bad_chg = 0;
  int exp_vld = 0, exp_sync = 0, exp_to = 0;
  logic [15:0] exp_cnt   = 16'd0;
  logic [23:0] prev_data = 24'd0;

  // Strobe counters and data-stability watch, sampled mid-cycle.
  always @(negedge clk_sys) begin
    if (rst_n) begin
      seen_vld  <= seen_vld  + int'(bus.ps2pkt_vld);
      seen_sync <= seen_sync + int'(bus.sync_err);
      seen_to   <= seen_to   + int'(bus.timeout_err);
      if (int'(bus.ps2pkt_vld) + int'(bus.sync_err) + int'(bus.timeout_err) > 1)
        seen_multi <= seen_multi + 1;
      if (!bus.ps2pkt_vld && bus.ps2pkt_data != prev_data)
        seen_bad_chg <= seen_bad_chg + 1;
    end
    prev_data <= bus.ps2pkt_data;
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] d);
    bus.byte_vld  = 1'b1;
    bus.byte_data = d;
    tick();
    bus.byte_vld  = 1'b0;
    bus.byte_data = 8'hA5;
  endtask

  task automatic send_err(input logic vld, input logic [7:0] d);
    bus.byte_vld  = vld;
    bus.byte_err  = 1'b1;
    bus.byte_data = d;
    tick();
    bus.byte_vld  = 1'b0;
    bus.byte_err  = 1'b0;
    bus.byte_data = 8'hA5;
  endtask

  task automatic check_pkt(input string nm, input logic [23:0] d);
    exp_cnt = exp_cnt + 16'd1;
    exp_vld++;
    check({nm, "_vld"},  32'(bus.ps2pkt_vld),  32'h1);
    check({nm, "_data"}, 32'(bus.ps2pkt_data), 32'(d));
    check({nm, "_cnt"},  32'(bus.pkt_cnt),     32'(exp_cnt));
    $display("pkt %s: data=0x%06h cnt=%0d", nm, bus.ps2pkt_data, bus.pkt_cnt);
  endtask

  task automatic send_pkt(input string nm, input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [23:0] d);
    send(b0);
    send(b1);
    send(b2);
    check_pkt(nm, d);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    pkt_vec_t tbl[5];
    tbl[0] = '{8'h09, 8'h05, 8'hFB, 1000,   24'hFB0509};
    tbl[1] = '{8'h08, 8'h10, 8'h20, 0,      24'h201008};
    tbl[2] = '{8'hFF, 8'hF7, 8'h08, 3,      24'h08F7FF};
    tbl[3] = '{8'h3A, 8'h00, 8'hFF, 0,      24'hFF003A};
    tbl[4] = '{8'h28, 8'h7F, 8'h01, TO - 1, 24'h017F28};

    bus.byte_vld  = 1'b0;
    bus.byte_data = 8'h00;
    bus.byte_err  = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    check("rst_vld",   32'(bus.ps2pkt_vld),  32'h0);
    check("rst_data",  32'(bus.ps2pkt_data), 32'h0);
    check("rst_sync",  32'(bus.sync_err),    32'h0);
    check("rst_to",    32'(bus.timeout_err), 32'h0);
    check("rst_cnt",   32'(bus.pkt_cnt),     32'h0);
    rst_n = 1'b1;
    en    = 1'b1;
    idle(TO + 10);  // no timeout may run while waiting for byte 0

    for (int i = 0; i < 5; i++) begin
      send(tbl[i].b0);
      idle(tbl[i].gap);
      send(tbl[i].b1);
      idle(tbl[i].gap);
      send(tbl[i].b2);
      check_pkt($sformatf("tbl%0d", i), tbl[i].exp_data);
      tick();
      check($sformatf("tbl%0d_vld_clr", i), 32'(bus.ps2pkt_vld), 32'h0);
      check($sformatf("tbl%0d_hold", i), 32'(bus.ps2pkt_data), 32'(tbl[i].exp_data));
    end

    // Back-to-back bytes spanning two packets
    send(8'h09); send(8'h01); send(8'h02);
    check_pkt("b2b_a", 24'h020109);
    send(8'h0D); send(8'h03); send(8'h04);
    check_pkt("b2b_b", 24'h04030D);
    tick();

    // Sync error on byte 0
    send(8'h02);
    exp_sync++;
    check("sync_pulse", 32'(bus.sync_err), 32'h1);
    tick();
    check("sync_clr", 32'(bus.sync_err), 32'h0);
    send_pkt("after_sync", 8'h08, 8'h10, 8'h20, 24'h201008);

    // Timeout while waiting for byte 1
    send(8'h08);
    idle(TO - 1);
    check("to_early", 32'(bus.timeout_err), 32'h0);
    tick();
    exp_to++;
    check("to_pulse", 32'(bus.timeout_err), 32'h1);
    tick();
    check("to_clr", 32'(bus.timeout_err), 32'h0);
    send_pkt("after_to", 8'h18, 8'h01, 8'hFF, 24'hFF0118);

    // Timeout while waiting for byte 2; next byte must be treated as byte 0
    send(8'h08); send(8'h11);
    idle(TO);
    exp_to++;
    check("to_b2_pulse", 32'(bus.timeout_err), 32'h1);
    send(8'h22);
    exp_sync++;
    check("to_b2_resync", 32'(bus.sync_err), 32'h1);

    // Byte arriving on the terminal-count cycle wins
    send(8'h08);
    idle(TO - 1);
    send(8'h7F);
    check("term_no_to", 32'(bus.timeout_err), 32'h0);
    send(8'h01);
    check_pkt("term", 24'h017F08);

    // byte_err on byte 2 discards the packet
    send(8'h08); send(8'h11);
    send_err(1'b1, 8'h22);
    check("err_no_vld", 32'(bus.ps2pkt_vld), 32'h0);
    send_pkt("after_err", 8'h09, 8'h00, 8'h00, 24'h000009);

    // byte_err without byte_vld still aborts; byte_err masks sync check
    send(8'h08);
    send_err(1'b0, 8'h55);
    send_pkt("err_novld", 8'h0A, 8'h0B, 8'h0C, 24'h0C0B0A);
    send_err(1'b1, 8'h02);
    check("err_no_sync", 32'(bus.sync_err), 32'h0);

    // Asynchronous reset mid-packet
    send(8'h09); send(8'h05);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_data", 32'(bus.ps2pkt_data), 32'h0);
    check("mid_rst_cnt",  32'(bus.pkt_cnt),     32'h0);
    check("mid_rst_vld",  32'(bus.ps2pkt_vld),  32'h0);
    exp_cnt = 16'd0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    send_pkt("after_rst", 8'h0C, 8'h01, 8'h02, 24'h02010C);

    // Enable dropped after byte 1
    send(8'h08); send(8'h33);
    en = 1'b0;
    tick();
    send(8'h44);
    check("dis_no_vld", 32'(bus.ps2pkt_vld), 32'h0);
    send(8'h02);
    check("dis_no_sync", 32'(bus.sync_err), 32'h0);
    idle(TO + 5);
    check("dis_data_kept", 32'(bus.ps2pkt_data), 32'h02010C);
    check("dis_cnt_kept",  32'(bus.pkt_cnt),     32'(exp_cnt));
    en = 1'b1;
    tick();
    send_pkt("after_en", 8'h09, 8'hAA, 8'hBB, 24'hBBAA09);

    // Packet counter wrap from 0xFFFF
    force dut.pkt_cnt_reg = 16'hFFFF;
    tick();
    release dut.pkt_cnt_reg;
    tick();
    check("preset_cnt", 32'(bus.pkt_cnt), 32'hFFFF);
    exp_cnt = 16'hFFFF;
    send_pkt("wrap", 8'h19, 8'h02, 8'h03, 24'h030219);
    check("wrap_zero", 32'(bus.pkt_cnt), 32'h0);

    tick();
    #5;
    check("tot_vld",   32'(seen_vld),     32'(exp_vld));
    check("tot_sync",  32'(seen_sync),    32'(exp_sync));
    check("tot_to",    32'(seen_to),      32'(exp_to));
    check("exclusive", 32'(seen_multi),   32'h0);
    check("data_hold", 32'(seen_bad_chg), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ps2_pkt_assembler.md
Name: ps2_pkt_assembler

Overview:
Assembles the 3-byte PS/2 mouse stream-mode packet from the byte-level PS/2 receiver into one 24-bit word. Sits directly upstream of the seven-segment/LED control stage and drives its ps2pkt_vld / ps2pkt_data inputs. Provides:
- byte-0 sync checking (bit 3 must be 1),
- an inter-byte timeout,
- error discard, so that only complete, aligned packets are passed downstream.

Parameters:
TIMEOUT_CYC, 100000, number of clk_sys cycles allowed between consecutive bytes of one packet (2 ms at 50 MHz); legal range 2..2^20.
CNT_W, 20, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
clk_sys  input  1  50 MHz system clock
rst_n  input  1  asynchronous active-low reset
en  input  1  assembler enable (high once mouse init has completed)
byte_vld  input  1  one-cycle strobe: byte_data holds a received byte
byte_data  input  8  received byte
byte_err  input  1  one-cycle strobe: parity/stop-bit error on the current byte
ps2pkt_vld  output  1  one-cycle strobe: ps2pkt_data holds a new packet
ps2pkt_data  output  24  {byte2 Y, byte1 X, byte0 status}; status[0]=L, [1]=R, [3]=1, [4]=X sign, [5]=Y sign, [6]=X ovf, [7]=Y ovf
sync_err  output  1  one-cycle strobe: byte 0 discarded because bit 3 was 0
timeout_err  output  1  one-cycle strobe: partial packet dropped on timeout
pkt_cnt  output  16  count of packets delivered, wraps from 0xFFFF to 0

Behaviour:
Reset values:
- All outputs 0.
- State = WAIT_B0.
- Timeout counter 0; internal byte registers 0.

State machine:
- WAIT_B0:
  - byte_vld & ~byte_err & byte_data[3]=1 → store byte0, clear counter, go to WAIT_B1.
  - byte_vld & ~byte_err & byte_data[3]=0 → byte discarded, sync_err pulses next cycle, stay in WAIT_B0.
  - No timeout runs in WAIT_B0.
- WAIT_B1:
  - byte_vld & ~byte_err → store byte1, clear counter, go to WAIT_B2.
- WAIT_B2:
  - byte_vld & ~byte_err → go to WAIT_B0.
  - Next cycle: ps2pkt_data <= {byte_data, byte1, byte0}, ps2pkt_vld=1, pkt_cnt+1.

Timing and data rules:
- Latency: ps2pkt_vld asserts exactly 1 cycle after the third byte_vld.
- ps2pkt_data holds its value until the next delivered packet and never changes without ps2pkt_vld.
- Byte 1 and byte 2 are not sync-checked (their bit 3 is data).

Timeout:
- In WAIT_B1/WAIT_B2 the counter increments each cycle without byte_vld.
- If the counter equals TIMEOUT_CYC-1 and byte_vld=0 → go to WAIT_B0, clear counter, timeout_err pulses next cycle.
- byte_vld in the same cycle as the terminal count wins: the byte is accepted and no timeout occurs.

byte_err:
- Any state, byte_err=1 (with or without byte_vld) → byte discarded, go to WAIT_B0, clear counter.
- No error strobe for byte_err; the receiver reports it itself.
- byte_err has priority over byte_vld and timeout.

en:
- en=0 → state forced to WAIT_B0 and counter cleared next cycle; bytes ignored.
- No strobes while en=0; ps2pkt_data and pkt_cnt are retained.
- Dropping en mid-packet discards the partial packet silently.

Strobes:
- All strobes are mutually exclusive and single-cycle.
- Back-to-back byte_vld on consecutive cycles must be accepted without loss.

Test Plan:
- Bytes 0x09, 0x05, 0xFB spaced 1000 cycles → one ps2pkt_vld pulse, 1 cycle after the third byte; ps2pkt_data=0xFB0509; pkt_cnt=1.
- Bytes 0x02 then 0x08, 0x10, 0x20 → sync_err pulse after 0x02; then ps2pkt_data=0x201008; no other strobes.
- Byte 0x08, then idle TIMEOUT_CYC cycles → timeout_err pulses once; next 0x18, 0x01, 0xFF → ps2pkt_data=0xFF0118.
- Byte 0x08, then 0x7F arriving exactly on the terminal-count cycle → accepted, no timeout_err; 0x01 → ps2pkt_data=0x017F08.
- 0x08, 0x11, then 0x22 with byte_err=1 → no ps2pkt_vld; state WAIT_B0; next 0x09, 0x00, 0x00 → ps2pkt_data=0x000009.
- rst_n asserted mid-packet (after byte 1), and separately en dropped after byte 1 → all outputs 0 after reset; with en dropped, no output change; full packet after re-enable delivers normally; pkt_cnt preset to 0xFFFF wraps to 0.
